// File: rtl/seg7_hex_reader.sv
// Recovers 4-bit character codes from an active-low 7-segment bus once a pattern has been stable for STABLE_CYCLES samples.
// Accept lands STABLE_CYCLES+1 edges after the input settles; a full FIFO drops new codes and sets the sticky overflow flag.
module seg7_hex_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       seg_in,
    input  logic             seg_en,
    output logic [3:0]       code_out,
    output logic             ambig_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic             fifo_full,
    output logic             overflow
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [SW-1:0] CNT_ACCEPT = SW'(STABLE_CYCLES);
    localparam logic [AW:0]   OCC_FULL   = (AW+1)'(FIFO_DEPTH);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SETTLING = 2'd1;
    localparam logic [1:0] LOCKED   = 2'd2;

    typedef struct packed {
        logic       ambig;
        logic [3:0] code;
    } entry_t;

    logic [6:0]    seg_q, cand, cand_nx;
    logic          en_q;
    logic [1:0]    state, state_nx;
    logic [SW-1:0] cnt, cnt_nx;
    logic          accept;

    always_comb begin
        state_nx = state;
        cand_nx  = cand;
        cnt_nx   = cnt;
        accept   = 1'b0;
        if (!en_q) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else if (state == IDLE || seg_q != cand) begin
            cand_nx  = seg_q;
            cnt_nx   = SW'(1);
            state_nx = SETTLING;
            if (STABLE_CYCLES == 1) begin
                accept   = 1'b1;
                state_nx = LOCKED;
            end
        end else if (state == SETTLING) begin
            cnt_nx = cnt + SW'(1);
            if (cnt_nx == CNT_ACCEPT) begin
                accept   = 1'b1;
                state_nx = LOCKED;
            end
        end
    end

    // Z and S reuse the patterns of 2 and 5, so they come back as the digit with ambig set.
    logic       dec_valid, dec_blank, dec_ambig;
    logic [3:0] dec_code;

    always_comb begin
        dec_valid = 1'b1;
        dec_blank = 1'b0;
        dec_ambig = 1'b0;
        dec_code  = 4'h0;
        case (cand_nx)
            7'h40: dec_code = 4'h0;
            7'h79: dec_code = 4'h1;
            7'h24: begin dec_code = 4'h2; dec_ambig = 1'b1; end
            7'h30: dec_code = 4'h3;
            7'h19: dec_code = 4'h4;
            7'h12: begin dec_code = 4'h5; dec_ambig = 1'b1; end
            7'h02: dec_code = 4'h6;
            7'h78: dec_code = 4'h7;
            7'h00: dec_code = 4'h8;
            7'h18: dec_code = 4'h9;
            7'h09: dec_code = 4'hA;
            7'h11: dec_code = 4'hB;
            7'h2F: dec_code = 4'hD;
            7'h4E: dec_code = 4'hF;
            7'h7F: begin dec_valid = 1'b0; dec_blank = 1'b1; end
            default: dec_valid = 1'b0;
        endcase
    end

    logic push, bad;
    assign push = accept & dec_valid;
    assign bad  = accept & ~dec_valid & ~dec_blank;

    entry_t        mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   occ;
    logic          pop, push_ok;
    entry_t        head;

    assign out_valid = (occ != '0);
    assign fifo_full = (occ == OCC_FULL);
    assign pop       = out_valid & out_ready;
    assign push_ok   = push & (~fifo_full | pop);
    assign head      = mem[rd_ptr];
    assign code_out  = out_valid ? head.code  : 4'h0;
    assign ambig_out = out_valid ? head.ambig : 1'b0;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= '{ambig: dec_ambig, code: dec_code};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q     <= '0;
            en_q      <= 1'b0;
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
            overflow  <= 1'b0;
        end else begin
            seg_q     <= seg_in;
            en_q      <= seg_en;
            state     <= state_nx;
            cand      <= cand_nx;
            cnt       <= cnt_nx;
            err_pulse <= bad;
            if (bad && err_count != {CNT_W{1'b1}}) begin
                err_count <= err_count + CNT_W'(1);
            end
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end
endmodule
